// File: rtl/cpu_pkg.sv
// Shared types and clock-derived constants for the CPU/LED top level and its
// pad-conditioning blocks.
package cpu_pkg;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } btn_state_t;

    localparam int unsigned CLK_HZ = 48000000;

    // 10 ms stability window and 1 s long-press hold at CLK_HZ.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int unsigned DEFAULT_LONG_CYCLES     = CLK_HZ;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs; both flops reset to
// RESET_VALUE so the idle pad level is seen straight out of reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit level plus
// press/release pulses; long-press pulse is built only with BTN_LONG_PRESS_EN.
module btn_debounce
    import cpu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic clk48,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic PAD_IDLE = (ACTIVE_LOW != 0);

    logic padSync;
    logic s;

    sync_2ff #(
        .RESET_VALUE(PAD_IDLE)
    ) u_sync (
        .clk_i(clk48),
        .rst_i(rst),
        .d_i  (btn_in),
        .q_o  (padSync)
    );

    assign s = padSync ^ PAD_IDLE;

    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // The window counter only advances while the new level is stable; any
    // disagreement in a WAIT state falls back without a pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            UP: begin
                if (s) begin
                    state_d = WAIT_DOWN;
                    cnt_d   = '0;
                end
            end
            WAIT_DOWN: begin
                if (!s) begin
                    state_d = UP;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DOWN;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DOWN: begin
                if (!s) begin
                    state_d = WAIT_UP;
                    cnt_d   = '0;
                end
            end
            WAIT_UP: begin
                if (s) begin
                    state_d = DOWN;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = UP;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = UP;
            end
        endcase
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state_q   <= UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned HW = $clog2(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 2);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // hold saturates so the long pulse fires at most once per press; a release
    // on the same edge wins so the pulses never overlap.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if ((state_q == DOWN || state_q == WAIT_UP) && hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
            long_d = (hold_q == HOLD_PRE) && !release_d;
        end
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// active-low pad; outputs are compared as {level, press, release, long}.
module tb_btn_debounce;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
`ifdef BTN_LONG_PRESS_EN
    localparam logic LONG_EN = 1'b1;
`else
    localparam logic LONG_EN = 1'b0;
`endif

    logic clk48 = 1'b0;
    logic rst;
    logic btnIn;
    logic btnLevel;
    logic btnPress;
    logic btnRelease;
    logic btnLong;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk48 = ~clk48;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk48      (clk48),
        .rst        (rst),
        .btn_in     (btnIn),
        .btn_level  (btnLevel),
        .btn_press  (btnPress),
        .btn_release(btnRelease),
        .btn_long   (btnLong)
    );

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expected);
        logic [3:0] observed;
        observed = {btnLevel, btnPress, btnRelease, btnLong};
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        logic [3:0] expected;

        rst   = 1'b1;
        btnIn = 1'b1;
        tick();
        tick();
        checkOutput("reset", 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            tick();
            checkOutput($sformatf("idle[%0d]", i), 4'b0000);
        end

        // Press, a 2-cycle bounce back up, then hold well past the long window.
        btnIn = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            if (k == 9)  btnIn = 1'b1;
            if (k == 11) btnIn = 1'b0;
            tick();
            if (k < 7)                      expected = 4'b0000;
            else if (k == 7)                expected = 4'b1100;
            else if (k == 26 && LONG_EN)    expected = 4'b1001;
            else                            expected = 4'b1000;
            checkOutput($sformatf("press[%0d]", k), expected);
        end

        btnIn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 7)       expected = 4'b1000;
            else if (k == 7) expected = 4'b0010;
            else             expected = 4'b0000;
            checkOutput($sformatf("release[%0d]", k), expected);
        end

        btnIn = 1'b0;
        tick();
        tick();
        btnIn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checkOutput($sformatf("glitch[%0d]", k), 4'b0000);
        end

        // Reset while the FSM is in WAIT_DOWN with the pad still pressed.
        btnIn = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput($sformatf("waitDown[%0d]", k), 4'b0000);
        end
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rstWaitDown", 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 7)       expected = 4'b0000;
            else if (k == 7) expected = 4'b1100;
            else             expected = 4'b1000;
            checkOutput($sformatf("repress[%0d]", k), expected);
        end

        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncDrop", 4'b0000);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            expected = (k == 7) ? 4'b1100 : 4'b0000;
            checkOutput($sformatf("afterRst[%0d]", k), expected);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
